// File: rtl/imgproc_report_scheduler_if.sv
// imgproc_report_scheduler_if: MSG_FIFO write port between the report scheduler and the CPU message FIFO
//   fifo_wr     scheduler -> FIFO  write request
//   fifo_data   scheduler -> FIFO  32-bit write word
//   fifo_usedw  FIFO -> scheduler  current fill level in words
interface imgproc_report_scheduler_if;
   logic        fifo_wr;
   logic [31:0] fifo_data;
   logic [7:0]  fifo_usedw;
   modport master (output fifo_wr, fifo_data, input fifo_usedw);
   modport slave (input fifo_wr, fifo_data, output fifo_usedw);
endinterface

// File: rtl/imgproc_report_scheduler.sv
// imgproc_report_scheduler: writes one 8-word detection report (header + seven areas) per MSG_INTERVAL video frames into the CPU message FIFO
//   clk           clock
//   reset_n       synchronous active-low reset
//   frame_done_i  1-cycle video end-of-frame pulse
//   area_in_i     seven AREA_W colour areas {building,...,red}, red in LSBs
//   enable_i      0 blocks new reports
//   flush_i       FIFO flush strobe, aborts the report in progress
//   fifo          MSG_FIFO write port (master side)
//   busy_o        report in progress
//   frame_seq_o   video frames seen
//   skip_cnt_o    due reports not started (saturating)
module imgproc_report_scheduler #(
   parameter int         MSG_INTERVAL = 6,
   parameter int         BUF_DEPTH    = 256,
   parameter int         AREA_W       = 12,
   parameter logic [7:0] HDR_TAG      = 8'hA5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  frame_done_i,
   input  logic [7*AREA_W-1:0]   area_in_i,
   input  logic                  enable_i,
   input  logic                  flush_i,
   imgproc_report_scheduler_if.master fifo,
   output logic                  busy_o,
   output logic [15:0]           frame_seq_o,
   output logic [7:0]            skip_cnt_o
);
   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
   state_t              state_q;
   logic [2:0]          idx_q;
   logic [7:0]          frame_cnt_q;
   logic [15:0]         frame_seq_q;
   logic [7:0]          skip_q;
   logic                wr_q;
   logic [31:0]         data_q;
   logic [AREA_W-1:0]   snap_q [0:6];
   logic                due_d, room_d, start_d;
   function automatic logic [31:0] area_word(input logic [2:0] i, input logic [AREA_W-1:0] a);
      return {13'd0, i, 16'(a)};
   endfunction
   // The whole 8-word report must fit, since the FIFO cannot push back.
   assign room_d  = {24'd0, fifo.fifo_usedw} <= 32'(BUF_DEPTH - 8);
   assign due_d   = frame_done_i && frame_cnt_q == 8'd0;
   // flush takes priority over a simultaneous start.
   assign start_d = due_d && enable_i && state_q == IDLE && room_d && !flush_i;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         idx_q       <= 3'd0;
         frame_cnt_q <= 8'(MSG_INTERVAL - 1);
         frame_seq_q <= 16'd0;
         skip_q      <= 8'd0;
         wr_q        <= 1'b0;
         data_q      <= 32'd0;
         for (int i = 0; i < 7; i++) snap_q[i] <= '0;
      end else begin
         if (frame_done_i) frame_seq_q <= frame_seq_q + 16'd1;
         if (frame_done_i && frame_cnt_q != 8'd0) frame_cnt_q <= frame_cnt_q - 8'd1;
         else if (start_d) frame_cnt_q <= 8'(MSG_INTERVAL - 1);
         else if (due_d && enable_i && skip_q != 8'hFF) skip_q <= skip_q + 8'd1;
         if (flush_i) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  wr_q <= start_d;
                  if (start_d) begin
                     state_q <= HDR;
                     data_q  <= {HDR_TAG, frame_seq_q, 8'd7};
                     for (int i = 0; i < 7; i++) snap_q[i] <= area_in_i[i*AREA_W +: AREA_W];
                  end
               end
               HDR: begin
                  state_q <= DATA;
                  idx_q   <= 3'd0;
                  wr_q    <= 1'b1;
                  data_q  <= area_word(3'd0, snap_q[0]);
               end
               DATA: begin
                  state_q <= idx_q == 3'd6 ? IDLE : DATA;
                  wr_q    <= idx_q != 3'd6;
                  if (idx_q != 3'd6) begin
                     idx_q  <= idx_q + 3'd1;
                     data_q <= area_word(idx_q + 3'd1, snap_q[idx_q + 3'd1]);
                  end
               end
               default: begin
                  state_q <= IDLE;
                  wr_q    <= 1'b0;
               end
            endcase
         end
      end
   end
   assign fifo.fifo_wr   = wr_q;
   assign fifo.fifo_data = data_q;
   assign busy_o         = state_q != IDLE;
   assign frame_seq_o    = frame_seq_q;
   assign skip_cnt_o     = skip_q;
endmodule

// File: tb/tb_imgproc_report_scheduler.sv
// tb_imgproc_report_scheduler: directed and randomized checks of the report scheduler against a queue-based report model
module tb_imgproc_report_scheduler;
   localparam int INTERVAL = 6;
   logic        clk = 1'b0;
   logic        reset_n, frame_done, enable, flush;
   logic [83:0] area;
   logic        busy;
   logic [15:0] frame_seq;
   logic [7:0]  skip;
   int          n_chk = 0, n_err = 0;
   logic [31:0] got [$];
   int          m_cnt;
   logic [15:0] m_seq;
   logic [7:0]  m_skip;
   logic [31:0] m_q [$];
   logic        m_act;
   logic [31:0] m_word;
   imgproc_report_scheduler_if bus ();
   imgproc_report_scheduler #(.MSG_INTERVAL(INTERVAL)) dut (
      .clk(clk), .reset_n(reset_n), .frame_done_i(frame_done), .area_in_i(area),
      .enable_i(enable), .flush_i(flush), .fifo(bus.master),
      .busy_o(busy), .frame_seq_o(frame_seq), .skip_cnt_o(skip)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   // Reference: a report is a list of 8 words queued at start and emitted one per cycle.
   task automatic model(input bit fd, input bit en, input bit fl, input bit rn, input logic [7:0] uw);
      bit start = 0;
      if (!rn) begin
         m_cnt = INTERVAL - 1; m_seq = 0; m_skip = 0; m_q.delete(); m_act = 0; m_word = 0;
         return;
      end
      if (fd) begin
         if (m_cnt != 0) m_cnt--;
         else if (en && !m_act && uw <= 248 && !fl) begin start = 1; m_cnt = INTERVAL - 1; end
         else if (en && m_skip != 8'hFF) m_skip++;
      end
      if (start) begin
         m_q.push_back({8'hA5, m_seq, 8'd7});
         for (int i = 0; i < 7; i++) m_q.push_back({13'd0, 3'(i), 4'd0, area[i*12 +: 12]});
      end
      if (fd) m_seq++;
      if (fl) begin m_q.delete(); m_act = 0; end
      else if (m_q.size() != 0) begin m_word = m_q.pop_front(); m_act = 1; end
      else m_act = 0;
   endtask
   task automatic step(input bit fd, input bit en, input bit fl, input bit rn, input logic [7:0] uw);
      frame_done = fd; enable = en; flush = fl; reset_n = rn; bus.fifo_usedw = uw;
      @(posedge clk);
      model(fd, en, fl, rn, uw);
      @(negedge clk);
      check("wr", {31'd0, bus.fifo_wr}, {31'd0, m_act});
      if (m_act) check("data", bus.fifo_data, m_word);
      check("busy", {31'd0, busy}, {31'd0, m_act});
      check("seq", {16'd0, frame_seq}, {16'd0, m_seq});
      check("skip", {24'd0, skip}, {24'd0, m_skip});
      if (bus.fifo_wr) got.push_back(bus.fifo_data);
   endtask
   task automatic frames(input int n, input int gap, input logic [7:0] uw);
      for (int f = 0; f < n; f++) begin
         step(1, 1, 0, 1, uw);
         for (int g = 1; g < gap; g++) step(0, 1, 0, 1, uw);
      end
   endtask
   task automatic do_reset();
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      got.delete();
   endtask
   initial begin
      frame_done = 0; enable = 1; flush = 0; reset_n = 0; bus.fifo_usedw = 0;
      area = {12'hFFF, 12'h666, 12'h555, 12'h444, 12'h333, 12'h222, 12'h123};
      @(negedge clk);
      do_reset();
      frames(12, 10, 8'd0);
      check("t1_writes", got.size(), 16);
      check("t1_hdr0", got[0], 32'hA500_0507);
      check("t1_red", got[1], 32'h0000_0123);
      check("t1_bldg", got[7], 32'h0006_0FFF);
      check("t1_hdr1", got[8], 32'hA500_0B07);
      do_reset();
      frames(6, 2, 8'd249);
      check("t3_skip", {24'd0, skip}, 1);
      check("t3_none", got.size(), 0);
      frames(1, 10, 8'd0);
      check("t3_retry", got.size(), 8);
      check("t3_hdr", got[0], 32'hA500_0607);
      do_reset();
      frames(5, 2, 8'd0);
      frames(1, 10, 8'd248);
      check("t248_start", got.size(), 8);
      check("t248_skip", {24'd0, skip}, 0);
      do_reset();
      frames(5, 2, 8'd0);
      step(1, 1, 0, 1, 0);
      step(0, 1, 0, 1, 0);
      step(0, 1, 0, 1, 0);
      step(0, 1, 1, 1, 0);
      check("t4_busy", {31'd0, busy}, 0);
      frames(1, 8, 8'd0);
      check("t4_partial", got.size(), 3);
      frames(6, 10, 8'd0);
      check("t4_next", got.size(), 11);
      check("t4_hdr", got[3], 32'hA500_0B07);
      do_reset();
      frames(5, 2, 8'd0);
      step(1, 1, 0, 1, 0);
      step(0, 1, 0, 1, 0);
      step(0, 1, 0, 1, 0);
      step(0, 1, 0, 0, 0);
      check("t6_wr", {31'd0, bus.fifo_wr}, 0);
      check("t6_data", bus.fifo_data, 0);
      check("t6_seq", {16'd0, frame_seq}, 0);
      got.delete();
      frames(5, 2, 8'd0);
      check("t6_early", got.size(), 0);
      frames(1, 10, 8'd0);
      check("t6_again", got.size(), 8);
      check("t6_hdr", got[0], 32'hA500_0507);
      do_reset();
      frames(300, 2, 8'd255);
      check("t5_sat", {24'd0, skip}, 255);
      do_reset();
      for (int s = 0; s < 4000; s++) begin
         area = 84'({$urandom(), $urandom(), $urandom()});
         step($urandom_range(0, 3) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0,
              $urandom_range(0, 499) != 0,
              $urandom_range(0, 1) == 1 ? 8'($urandom_range(244, 252)) : 8'($urandom_range(0, 255)));
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
